// File: rtl/imm_pkg.sv
// Shared opcode constants and format/occupancy encodings for the immediate decode pipe.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_REG32  = 7'h3B;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV opcode classifier and sign-extended immediate former.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm32   = '0;
        fmt     = FMT_ILL;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_FENCE, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_REG, OP_REG32: begin
                fmt   = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // every format keeps its sign in bit 31, so one widening covers both XLENs
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decoder followed by a 2-entry result FIFO and a saturating illegal-opcode counter.
//
// state    | meaning
// ST_EMPTY | no result held, out_valid low
// ST_ONE   | head register holds the presented result
// ST_FULL  | head presented, second result parked in slot, in_ready low
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output fmt_e             out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    occ_e             state;
    logic [XLEN-1:0]  dec_imm, slot_imm;
    fmt_e             dec_fmt, slot_fmt;
    logic             dec_ill, slot_ill;
    logic [TAG_W-1:0] slot_tag;
    logic             push, pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready    <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= FMT_R;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            slot_imm    <= '0;
            slot_fmt    <= FMT_R;
            slot_ill    <= 1'b0;
            slot_tag    <= '0;
            illegal_cnt <= '0;
        end else begin
            // in_ready tracks the next state so it never depends on out_ready combinationally
            in_ready <= !((state == ST_ONE && push && !pop) || (state == ST_FULL && !pop));
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        out_imm     <= dec_imm;
                        out_fmt     <= dec_fmt;
                        out_illegal <= dec_ill;
                        out_tag     <= in_tag;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        out_imm     <= dec_imm;
                        out_fmt     <= dec_fmt;
                        out_illegal <= dec_ill;
                        out_tag     <= in_tag;
                    end else if (push) begin
                        slot_imm <= dec_imm;
                        slot_fmt <= dec_fmt;
                        slot_ill <= dec_ill;
                        slot_tag <= in_tag;
                        state    <= ST_FULL;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        out_imm     <= slot_imm;
                        out_fmt     <= slot_fmt;
                        out_illegal <= slot_ill;
                        out_tag     <= slot_tag;
                        state       <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase

            if (cnt_clr) begin
                illegal_cnt <= '0;
            end else if (push && dec_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each instruction.
REQ-003 SHALL have parameter CNT_W, default 16, width of the illegal-opcode counter.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  in  1  instruction offered.
REQ-007 SHALL have port in_ready  out  1  block accepts instruction this cycle.
REQ-008 SHALL have port in_instr  in  32  RV instruction word.
REQ-009 SHALL have port in_tag  in  TAG_W  sideband, passed through unchanged.
REQ-010 SHALL have port out_valid  out  1  result available.
REQ-011 SHALL have port out_ready  in  1  consumer accepts result.
REQ-012 SHALL have port out_imm  out  XLEN  sign-extended immediate.
REQ-013 SHALL have port out_fmt  out  3  format code (package enum).
REQ-014 SHALL have port out_illegal  out  1  opcode not recognised.
REQ-015 SHALL have port out_tag  out  TAG_W  tag of the presented result.
REQ-016 SHALL have port cnt_clr  in  1  synchronous clear of illegal counter.
REQ-017 SHALL have port illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-018 SHALL decode in_instr[6:0]: I = 0x03,0x0F,0x13,0x1B,0x67,0x73; S = 0x23; B = 0x63; U = 0x37,0x17; J = 0x6F; R = 0x33,0x3B; any other opcode illegal.
REQ-019 SHALL form immediates, sign bit in_instr[31] replicated to XLEN: I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}.
REQ-020 SHALL output out_imm = 0 for R format and illegal opcodes; out_illegal = 1 only for illegal opcodes.
REQ-021 SHALL use out_fmt encoding R=0, I=1, S=2, B=3, U=4, J=5, ILL=7; 6 unused.
REQ-022 SHALL accept an instruction on any cycle with in_valid && in_ready; the transfer completes on a cycle with out_valid && out_ready.
REQ-023 SHALL buffer decoded results in a 2-entry FIFO; latency from acceptance to out_valid is exactly 1 cycle when the FIFO is empty.
REQ-024 SHALL track occupancy with states EMPTY, ONE, FULL: push-only advances, pop-only retreats, push+pop holds; push is never accepted in FULL.
REQ-025 SHALL drive in_ready = (state != FULL), derived from registered state only (no combinational path from out_ready).
REQ-026 SHALL present results in acceptance order; out_imm/out_fmt/out_illegal/out_tag SHALL hold stable while out_valid && !out_ready.
REQ-027 SHALL increment illegal_cnt by 1 on each accepted illegal instruction, saturating at 2^CNT_W-1.
REQ-028 SHALL give cnt_clr priority over an increment in the same cycle (result 0).

Reset
REQ-029 SHALL, on rst_n low, immediately force state EMPTY, out_valid=0, in_ready=0 during reset, illegal_cnt=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
REQ-030 SHALL discard all buffered entries on reset mid-operation; in_ready SHALL be 1 on the first clock edge after rst_n deasserts.

Structure
REQ-031 SHALL place opcode constants and the format enum in shared package imm_pkg.
REQ-032 SHALL use one combinational sub-module imm_decode (instr in; imm, fmt, illegal out, XLEN parameter), feeding the FIFO.

Verification
REQ-033 SHALL check 0xFFF00093 (addi x1,x0,-1), XLEN=64 -> one cycle later out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=I.
REQ-034 SHALL check 0x00112623 -> out_imm=12, fmt S; 0xFE000EE3 -> out_imm=0xFFFFFFFFFFFFFFFC, fmt B.
REQ-035 SHALL check 0x800000B7 -> XLEN=64 out_imm=0xFFFFFFFF80000000; XLEN=32 out_imm=0x80000000.
REQ-036 SHALL hold out_ready=0 and offer 3 instructions -> in_ready low after 2 accepted; then out_ready=1 -> all 3 delivered in order, tags intact.
REQ-037 SHALL issue 0x0000007F with CNT_W=2 five times -> out_illegal=1, out_imm=0, illegal_cnt saturates at 3; cnt_clr with coincident illegal -> 0.
REQ-038 SHALL assert rst_n low with FULL FIFO -> out_valid=0 and illegal_cnt=0 immediately, no stale entry after release.
